// File: rtl/seq_det_pkg.sv
// Shared types for the programmable serial pattern detector: FSM state encoding
// and a sizing helper for the history fill counter.
package seq_det_pkg;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    HUNT  = 2'd1,
    HIT   = 2'd2
  } state_e;

  // Bits needed to hold a fill level from 0 up to and including pat_w.
  function automatic int fill_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage : seq_det_pkg

// File: rtl/seq_det_cnt.sv
// Saturating event counter: counts inc pulses up to all-ones, clr wins over
// a plain hold, and a clear coinciding with an increment leaves the count at 1.
module seq_det_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? CNT_ONE : '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_ONE;
    end
  end

endmodule : seq_det_cnt

// File: rtl/seq_detect_prog.sv
// Programmable serial sequence detector with a Moore match flag. Define
// SEQ_DETECT_CNT_EN to build the saturating match counter; otherwise cnt is 0.
module seq_detect_prog
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic             i_bit,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_val,
  input  logic             ovl,
  input  logic             cnt_clr,
  output logic             y,
  output logic [CNT_W-1:0] cnt
);

  localparam int               FILL_W    = fill_width(PAT_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);

  state_e             state_q;
  state_e             state_d;
  logic [PAT_W-1:0]   pat_q;
  logic [PAT_W-2:0]   hist_q;
  logic [FILL_W-1:0]  fill_q;

  logic               take_bit;
  logic [PAT_W-1:0]   window;
  logic               match;

  // A bit is consumed only once configured, and never in a pattern-load cycle.
  assign take_bit = (state_q != UNCFG) && i_valid && !pat_load;
  assign window   = {hist_q, i_bit};
  assign match    = take_bit && (fill_q >= FILL_LAST) && (window == pat_q);

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= UNCFG;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- next-state logic ----------------
  // NOTE: state_d gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (pat_load) begin
      state_d = HUNT;
    end else begin
      unique case (state_q)
        UNCFG:   state_d = UNCFG;
        HUNT:    state_d = match ? HIT : HUNT;
        HIT:     state_d = match ? HIT : HUNT;
        default: state_d = UNCFG;
      endcase
    end
  end

  // ---------------- output decode ----------------
  always_comb begin
    y = (state_q == HIT);
  end

  // ---------------- pattern, history and fill ----------------
  // NOTE: the pattern/history registers are cleared by reset because a stale
  // pattern must never be matchable before a fresh load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q  <= '0;
      hist_q <= '0;
      fill_q <= '0;
    end else if (pat_load) begin
      pat_q  <= pat_val;
      hist_q <= '0;
      fill_q <= '0;
    end else if (take_bit) begin
      hist_q <= window[PAT_W-2:0];
      if (match && !ovl) begin
        fill_q <= '0;
      end else if (fill_q != FILL_FULL) begin
        fill_q <= fill_q + FILL_ONE;
      end
    end
  end

  // ---------------- optional match counter ----------------
`ifdef SEQ_DETECT_CNT_EN
  seq_det_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (match),
    .clr (cnt_clr),
    .cnt (cnt)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign cnt            = '0;
`endif

endmodule : seq_detect_prog

// File: tb/tb_seq_detect_prog.sv
// Self-checking bench for seq_detect_prog (PAT_W=4, CNT_W=2): a reference model
// queues the expected y/cnt per clock and the sampled DUT outputs are popped against it.
module tb_seq_detect_prog;

  localparam int PAT_W = 4;
  localparam int CNT_W = 2;
`ifdef SEQ_DETECT_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  typedef struct packed {
    logic             y;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             i_valid;
  logic             i_bit;
  logic             pat_load;
  logic [PAT_W-1:0] pat_val;
  logic             ovl;
  logic             cnt_clr;
  logic             y;
  logic [CNT_W-1:0] cnt;

  int   n_total = 0;
  int   n_bad   = 0;
  int   y_seen  = 0;
  int   cyc     = 0;
  exp_t sb[$];

  // reference model state
  logic             m_cfg;
  logic [PAT_W-1:0] m_pat;
  logic [PAT_W-1:0] m_bits;
  int               m_fill;
  int               m_cnt;

  seq_detect_prog #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (i_valid),
    .i_bit    (i_bit),
    .pat_load (pat_load),
    .pat_val  (pat_val),
    .ovl      (ovl),
    .cnt_clr  (cnt_clr),
    .y        (y),
    .cnt      (cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int exp_cnt(input int v);
    return (CNT_ON != 0) ? v : 0;
  endfunction

  task automatic model_reset();
    m_cfg  = 1'b0;
    m_pat  = '0;
    m_bits = '0;
    m_fill = 0;
    m_cnt  = 0;
  endtask

  // One clock: drive inputs, predict the post-edge outputs, then compare.
  task automatic step(input logic v, input logic b, input logic pl,
                      input logic [PAT_W-1:0] pv, input logic cc);
    exp_t e;
    logic m;
    i_valid  = v;
    i_bit    = b;
    pat_load = pl;
    pat_val  = pv;
    cnt_clr  = cc;
    m = 1'b0;
    if (pl) begin
      m_cfg  = 1'b1;
      m_pat  = pv;
      m_bits = '0;
      m_fill = 0;
    end else if (m_cfg && v) begin
      m_bits = {m_bits[PAT_W-2:0], b};
      if (m_fill < PAT_W) m_fill++;
      if (m_fill == PAT_W && m_bits == m_pat) begin
        m = 1'b1;
        if (!ovl) m_fill = 0;
      end
    end
    if (CNT_ON != 0) begin
      if (cc)                                 m_cnt = m ? 1 : 0;
      else if (m && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end
    e.y   = m;
    e.cnt = m_cnt[CNT_W-1:0];
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    e = sb.pop_front();
    check("y", {31'd0, y}, {31'd0, e.y});
    check("cnt", {30'd0, cnt}, {30'd0, e.cnt});
    if (y === 1'b1) y_seen++;
  endtask

  task automatic send_bit(input logic b);
    step(1'b1, b, 1'b0, '0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic load(input logic [PAT_W-1:0] pv);
    step(1'b0, 1'b0, 1'b1, pv, 1'b0);
    y_seen = 0;
  endtask

  task automatic clr_cnt();
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic send_bits(input logic [7:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(bits[i]);
  endtask

  initial begin
    rst = 1'b1; i_valid = 0; i_bit = 0; pat_load = 0; pat_val = '0; ovl = 0; cnt_clr = 0;
    model_reset();
    #22;
    check("rst_y", {31'd0, y}, 32'd0);
    check("rst_cnt", {30'd0, cnt}, 32'd0);
    rst = 1'b0;

    // Unconfigured: zeros must not match the reset pattern 0000.
    y_seen = 0;
    send_bits(8'b0000_0000, 6);
    check("uncfg_pulses", y_seen, 0);

    // Basic 1010 detect, one cycle latency.
    ovl = 1'b0;
    load(4'b1010);
    send_bits(8'b0000_1010, 4);
    idle(2);
    check("basic_pulses", y_seen, 1);
    check("basic_cnt", {30'd0, cnt}, exp_cnt(1));

    // Overlapping 101010 -> two pulses.
    clr_cnt();
    ovl = 1'b1;
    load(4'b1010);
    send_bits(8'b0010_1010, 6);
    idle(2);
    check("ovl_pulses", y_seen, 2);
    check("ovl_cnt", {30'd0, cnt}, exp_cnt(2));

    // Non-overlapping 101010 -> one pulse.
    clr_cnt();
    ovl = 1'b0;
    load(4'b1010);
    send_bits(8'b0010_1010, 6);
    idle(2);
    check("novl_pulses", y_seen, 1);
    check("novl_cnt", {30'd0, cnt}, exp_cnt(1));

    // Invalid gaps of 3 cycles between bits.
    clr_cnt();
    load(4'b1010);
    send_bit(1'b1); idle(3);
    send_bit(1'b0); idle(3);
    send_bit(1'b1); idle(3);
    send_bit(1'b0); idle(3);
    check("gap_pulses", y_seen, 1);

    // 1111 overlapping: 6 ones -> y high 3 cycles.
    clr_cnt();
    ovl = 1'b1;
    load(4'b1111);
    send_bits(8'b0011_1111, 6);
    check("ones_pulses", y_seen, 3);
    check("ones_cnt", {30'd0, cnt}, exp_cnt(3));
    // Five more matches: counter saturates at 3.
    clr_cnt();
    load(4'b1111);
    send_bits(8'b1111_1111, 8);
    check("sat_cnt", {30'd0, cnt}, exp_cnt(3));
    // Clear coincident with a match -> count is 1.
    step(1'b1, 1'b1, 1'b0, '0, 1'b1);
    check("clr_match_cnt", {30'd0, cnt}, exp_cnt(1));
    idle(1);

    // Reset after 3 pattern bits; no match until reload.
    ovl = 1'b0;
    load(4'b1010);
    send_bits(8'b0000_0101, 3);
    #2 rst = 1'b1;
    #1;
    check("midrst_y", {31'd0, y}, 32'd0);
    check("midrst_cnt", {30'd0, cnt}, 32'd0);
    model_reset();
    #1 rst = 1'b0;
    y_seen = 0;
    send_bit(1'b0);
    send_bits(8'b0000_1010, 4);
    check("postrst_pulses", y_seen, 0);
    load(4'b1010);
    send_bits(8'b0000_1010, 4);
    check("reload_pulses", y_seen, 1);
    idle(1);

    // Reload mid-pattern clears history; the bit in the load cycle is dropped.
    load(4'b1010);
    send_bits(8'b0000_0101, 3);
    step(1'b1, 1'b0, 1'b1, 4'b0110, 1'b0);
    y_seen = 0;
    send_bit(1'b0);
    check("reload_nohit", y_seen, 0);
    send_bits(8'b0000_0110, 4);
    check("fresh_0110", y_seen, 1);
    idle(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_seq_detect_prog
